// File: rtl/usb3_tp_arbiter.sv
// usb3_tp_arbiter: shares the link layer's single TP transmit port among three requesters.
// Define USB3_TP_ARB_RR_EN for round-robin selection; default is fixed priority a > b > c.
module usb3_tp_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [4:0]  LT_U0       = 5'd16
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic [4:0]  ltssm_state,

  input  logic        req_a,
  input  logic        req_a_retry,
  input  logic        req_a_dir,
  input  logic [3:0]  req_a_subtype,
  input  logic [3:0]  req_a_endp,
  input  logic [4:0]  req_a_nump,
  input  logic [4:0]  req_a_seq,
  input  logic [15:0] req_a_stream,

  input  logic        req_b,
  input  logic        req_b_retry,
  input  logic        req_b_dir,
  input  logic [3:0]  req_b_subtype,
  input  logic [3:0]  req_b_endp,
  input  logic [4:0]  req_b_nump,
  input  logic [4:0]  req_b_seq,
  input  logic [15:0] req_b_stream,

  input  logic        req_c,
  input  logic        req_c_retry,
  input  logic        req_c_dir,
  input  logic [3:0]  req_c_subtype,
  input  logic [3:0]  req_c_endp,
  input  logic [4:0]  req_c_nump,
  input  logic [4:0]  req_c_seq,
  input  logic [15:0] req_c_stream,

  output logic        ack_a,
  output logic        ack_b,
  output logic        ack_c,

  output logic        tx_tp,
  output logic        tx_tp_retry,
  output logic        tx_tp_dir,
  output logic [3:0]  tx_tp_subtype,
  output logic [3:0]  tx_tp_endp,
  output logic [4:0]  tx_tp_nump,
  output logic [4:0]  tx_tp_seq,
  output logic [15:0] tx_tp_stream,
  input  logic        tx_tp_ack,

  output logic [1:0]  grant,
  output logic        err_timeout,
  output logic        err_flush
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_e;

  typedef struct packed {
    logic        retry;
    logic        dir;
    logic [3:0]  subtype;
    logic [3:0]  endp;
    logic [4:0]  nump;
    logic [4:0]  seq;
    logic [15:0] stream;
  } tp_fields_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  tp_fields_t fld_q, fld_d;
  logic       tx_tp_q, tx_tp_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ack_q, ack_d;
  logic       err_to_q, err_to_d;
  logic       err_fl_q, err_fl_d;

  tp_fields_t fld_a, fld_b, fld_c, fld_sel;
  logic [1:0] win;

  assign fld_a = {req_a_retry, req_a_dir, req_a_subtype, req_a_endp, req_a_nump, req_a_seq, req_a_stream};
  assign fld_b = {req_b_retry, req_b_dir, req_b_subtype, req_b_endp, req_b_nump, req_b_seq, req_b_stream};
  assign fld_c = {req_c_retry, req_c_dir, req_c_subtype, req_c_endp, req_c_nump, req_c_seq, req_c_stream};

`ifdef USB3_TP_ARB_RR_EN
  logic [1:0] last_q, last_d;

  // Search begins at the requester after the last one granted.
  always_comb begin
    win = 2'd0;
    case (last_q)
      2'd1:    win = req_b ? 2'd2 : req_c ? 2'd3 : req_a ? 2'd1 : 2'd0;
      2'd2:    win = req_c ? 2'd3 : req_a ? 2'd1 : req_b ? 2'd2 : 2'd0;
      default: win = req_a ? 2'd1 : req_b ? 2'd2 : req_c ? 2'd3 : 2'd0;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && win != 2'd0) last_d = win;
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) last_q <= 2'd3;
    else          last_q <= last_d;
  end
`else
  always_comb begin
    win = req_a ? 2'd1 : req_b ? 2'd2 : req_c ? 2'd3 : 2'd0;
  end
`endif

  always_comb begin
    case (win)
      2'd1:    fld_sel = fld_a;
      2'd2:    fld_sel = fld_b;
      default: fld_sel = fld_c;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    fld_d    = fld_q;
    tx_tp_d  = tx_tp_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_to_d = err_to_q;
    err_fl_d = err_fl_q;

    case (state_q)
      ST_IDLE: begin
        if (win != 2'd0) begin
          state_d = ST_BUSY;
          grant_d = win;
          fld_d   = fld_sel;
          tx_tp_d = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // Link ack wins over timeout, timeout over flush.
        if (tx_tp_ack || cnt_q == TO_LAST || ltssm_state != LT_U0) begin
          ack_d[0] = (grant_q == 2'd1);
          ack_d[1] = (grant_q == 2'd2);
          ack_d[2] = (grant_q == 2'd3);
          tx_tp_d  = 1'b0;
          grant_d  = 2'd0;
          state_d  = ST_GAP;
          if (!tx_tp_ack) begin
            if (cnt_q == TO_LAST) err_to_d = 1'b1;
            else                  err_fl_d = 1'b1;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      fld_q    <= '0;
      tx_tp_q  <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_to_q <= 1'b0;
      err_fl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      fld_q    <= fld_d;
      tx_tp_q  <= tx_tp_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_to_q <= err_to_d;
      err_fl_q <= err_fl_d;
    end
  end

  assign ack_a         = ack_q[0];
  assign ack_b         = ack_q[1];
  assign ack_c         = ack_q[2];
  assign tx_tp         = tx_tp_q;
  assign tx_tp_retry   = fld_q.retry;
  assign tx_tp_dir     = fld_q.dir;
  assign tx_tp_subtype = fld_q.subtype;
  assign tx_tp_endp    = fld_q.endp;
  assign tx_tp_nump    = fld_q.nump;
  assign tx_tp_seq     = fld_q.seq;
  assign tx_tp_stream  = fld_q.stream;
  assign grant         = grant_q;
  assign err_timeout   = err_to_q;
  assign err_flush     = err_fl_q;

endmodule
